// File: rtl/alu_ctrl_flags.sv
// alu_ctrl_flags: opcode accept/decode stage for the 16-slice ALU.
// The stage registers one-hot slice controls for a single execute cycle and then
// captures the Z/N/C/V status flags from the MSB slice on the following edge.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no op in flight, controls zero, ready for an opcode
// EXEC  | controls driven to the slices, ALU_Out valid (ExecStrobe)
// CAP   | flags just captured (FlagsValid), ready for the next opcode
module alu_ctrl_flags #(
    parameter int         WIDTH    = 16,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       OpValid,
    output logic       OpReady,
    input  logic [3:0] Opcode,
    input  logic [3:0] ShAmt,
    output logic       SUB,
    output logic       ZeroA,
    output logic       CIn,
    output logic       FAOut,
    output logic       AND,
    output logic       OR,
    output logic       XOR,
    output logic       NOT,
    output logic       NAND,
    output logic       NOR,
    output logic       Sh8,
    output logic       Sh4,
    output logic       Sh2,
    output logic       Sh1,
    output logic       ShL,
    output logic       ShR,
    output logic       ShB,
    output logic       ShOut,
    input  logic       A_MSB,
    input  logic       B_MSB,
    input  logic       Sum_MSB,
    input  logic       COut_MSB,
    input  logic       Out_MSB,
    input  logic       ResultZero,
    output logic       ExecStrobe,
    output logic       WrEn,
    output logic       FlagsValid,
    output logic       Z,
    output logic       N,
    output logic       C,
    output logic       V
);

    // Only the sign slice (bit WIDTH-1) is observed here; a sign bit must exist.
    if (WIDTH < 2) begin : g_width_too_small
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAP  = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADC  = 4'h1,
        OP_SUB  = 4'h2,
        OP_SBC  = 4'h3,
        OP_NEG  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_NOT  = 4'h8,
        OP_NAND = 4'h9,
        OP_NOR  = 4'hA,
        OP_LSL  = 4'hB,
        OP_LSR  = 4'hC,
        OP_LSLB = 4'hD,
        OP_CMP  = 4'hE,
        OP_NOP  = 4'hF
    } op_e;

    typedef struct packed {
        logic       sub;
        logic       zero_a;
        logic       cin;
        logic       fa_out;
        logic       l_and;
        logic       l_or;
        logic       l_xor;
        logic       l_not;
        logic       l_nand;
        logic       l_nor;
        logic [3:0] sh_amt;
        logic       sh_l;
        logic       sh_r;
        logic       sh_b;
        logic       sh_out;
    } ctrl_t;

    state_e state_q, state_d;
    op_e    op_q, op_d;
    op_e    op_in;
    ctrl_t  ctrl_q, ctrl_d;
    logic   exec_strobe_q, exec_strobe_d;
    logic   wr_en_q, wr_en_d;
    logic   flags_valid_q, flags_valid_d;
    logic   z_q, z_d;
    logic   n_q, n_d;
    logic   c_q, c_d;
    logic   v_q, v_d;
    logic   op_ready;
    logic   accept;

    assign op_in    = op_e'(Opcode);
    assign op_ready = (state_q == ST_IDLE) || (state_q == ST_CAP);
    assign accept   = OpValid && op_ready;

    // Next-state logic; EXEC always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_CAP;
            ST_CAP:  state_d = OpValid ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode on the accept edge; on any other edge the controls return to zero.
    // ADC/SBC take the next-cycle carry so a flag update on the same edge is forwarded.
    always_comb begin
        ctrl_d        = '0;
        op_d          = op_q;
        exec_strobe_d = accept;
        wr_en_d       = accept && (op_in != OP_CMP) && (op_in != OP_NOP);
        if (accept) begin
            op_d = op_in;
            case (op_in)
                OP_ADD: begin
                    ctrl_d.fa_out = 1'b1;
                end
                OP_ADC: begin
                    ctrl_d.fa_out = 1'b1;
                    ctrl_d.cin    = c_d;
                end
                OP_SUB, OP_CMP: begin
                    ctrl_d.fa_out = 1'b1;
                    ctrl_d.sub    = 1'b1;
                    ctrl_d.cin    = 1'b1;
                end
                OP_SBC: begin
                    ctrl_d.fa_out = 1'b1;
                    ctrl_d.sub    = 1'b1;
                    ctrl_d.cin    = c_d;
                end
                OP_NEG: begin
                    ctrl_d.fa_out = 1'b1;
                    ctrl_d.sub    = 1'b1;
                    ctrl_d.zero_a = 1'b1;
                    ctrl_d.cin    = 1'b1;
                end
                OP_AND:  ctrl_d.l_and  = 1'b1;
                OP_OR:   ctrl_d.l_or   = 1'b1;
                OP_XOR:  ctrl_d.l_xor  = 1'b1;
                OP_NOT:  ctrl_d.l_not  = 1'b1;
                OP_NAND: ctrl_d.l_nand = 1'b1;
                OP_NOR:  ctrl_d.l_nor  = 1'b1;
                OP_LSL: begin
                    ctrl_d.sh_l   = 1'b1;
                    ctrl_d.sh_out = 1'b1;
                    ctrl_d.sh_amt = ShAmt;
                end
                OP_LSR: begin
                    ctrl_d.sh_r   = 1'b1;
                    ctrl_d.sh_out = 1'b1;
                    ctrl_d.sh_amt = ShAmt;
                end
                OP_LSLB: begin
                    ctrl_d.sh_l   = 1'b1;
                    ctrl_d.sh_b   = 1'b1;
                    ctrl_d.sh_out = 1'b1;
                    ctrl_d.sh_amt = ShAmt;
                end
                default: ctrl_d = '0;
            endcase
        end
    end

    // Flag capture on the EXEC->CAP edge from the MSB slice of the op in flight.
    always_comb begin
        z_d           = z_q;
        n_d           = n_q;
        c_d           = c_q;
        v_d           = v_q;
        flags_valid_d = (state_q == ST_EXEC);
        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_ADD, OP_ADC: begin
                    z_d = ResultZero;
                    n_d = Sum_MSB;
                    c_d = COut_MSB;
                    v_d = ~(A_MSB ^ B_MSB) & (A_MSB ^ Sum_MSB);
                end
                OP_SUB, OP_SBC, OP_CMP: begin
                    z_d = ResultZero;
                    n_d = Sum_MSB;
                    c_d = COut_MSB;
                    v_d = (A_MSB ^ B_MSB) & (A_MSB ^ Sum_MSB);
                end
                OP_NEG: begin
                    // A is forced to zero by ZeroA, so only B and the sum decide overflow.
                    z_d = ResultZero;
                    n_d = Sum_MSB;
                    c_d = COut_MSB;
                    v_d = B_MSB & Sum_MSB;
                end
                OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NAND, OP_NOR,
                OP_LSL, OP_LSR, OP_LSLB: begin
                    z_d = ResultZero;
                    n_d = Out_MSB;
                end
                default: begin
                    z_d = z_q;
                end
            endcase
        end
    end

    // State, control and flag registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_NOP;
            ctrl_q        <= '0;
            exec_strobe_q <= 1'b0;
            wr_en_q       <= 1'b0;
            flags_valid_q <= 1'b0;
            z_q           <= FLAG_RST[3];
            n_q           <= FLAG_RST[2];
            c_q           <= FLAG_RST[1];
            v_q           <= FLAG_RST[0];
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            ctrl_q        <= ctrl_d;
            exec_strobe_q <= exec_strobe_d;
            wr_en_q       <= wr_en_d;
            flags_valid_q <= flags_valid_d;
            z_q           <= z_d;
            n_q           <= n_d;
            c_q           <= c_d;
            v_q           <= v_d;
        end
    end

    assign OpReady    = op_ready;
    assign SUB        = ctrl_q.sub;
    assign ZeroA      = ctrl_q.zero_a;
    assign CIn        = ctrl_q.cin;
    assign FAOut      = ctrl_q.fa_out;
    assign AND        = ctrl_q.l_and;
    assign OR         = ctrl_q.l_or;
    assign XOR        = ctrl_q.l_xor;
    assign NOT        = ctrl_q.l_not;
    assign NAND       = ctrl_q.l_nand;
    assign NOR        = ctrl_q.l_nor;
    assign Sh8        = ctrl_q.sh_amt[3];
    assign Sh4        = ctrl_q.sh_amt[2];
    assign Sh2        = ctrl_q.sh_amt[1];
    assign Sh1        = ctrl_q.sh_amt[0];
    assign ShL        = ctrl_q.sh_l;
    assign ShR        = ctrl_q.sh_r;
    assign ShB        = ctrl_q.sh_b;
    assign ShOut      = ctrl_q.sh_out;
    assign ExecStrobe = exec_strobe_q;
    assign WrEn       = wr_en_q;
    assign FlagsValid = flags_valid_q;
    assign Z          = z_q;
    assign N          = n_q;
    assign C          = c_q;
    assign V          = v_q;

endmodule

// File: tb/tb_alu_ctrl_flags.sv
// Directed bench for alu_ctrl_flags: reset, arithmetic/logic/shift decode,
// flag capture, back-to-back carry forwarding and reset during execute.
module tb_alu_ctrl_flags;

    logic Clock = 1'b0;
    logic Reset, OpValid, OpReady;
    logic [3:0] Opcode, ShAmt;
    logic SUB, ZeroA, CIn, FAOut;
    logic AND, OR, XOR, NOT, NAND, NOR;
    logic Sh8, Sh4, Sh2, Sh1, ShL, ShR, ShB, ShOut;
    logic A_MSB, B_MSB, Sum_MSB, COut_MSB, Out_MSB, ResultZero;
    logic ExecStrobe, WrEn, FlagsValid, Z, N, C, V;

    int checks = 0;
    int failures = 0;

    // Control bit positions inside the packed observation vector.
    localparam int C_SUB = 17, C_ZA = 16, C_CIN = 15, C_FA = 14;
    localparam int C_AND = 13, C_OR = 12, C_XOR = 11, C_NOT = 10, C_NAND = 9, C_NOR = 8;
    localparam int C_SH8 = 7, C_SH4 = 6, C_SH2 = 5, C_SH1 = 4;
    localparam int C_SHL = 3, C_SHR = 2, C_SHB = 1, C_SHOUT = 0;

    logic [17:0] ctrl;
    logic [3:0]  flags;
    assign ctrl  = {SUB, ZeroA, CIn, FAOut, AND, OR, XOR, NOT, NAND, NOR,
                    Sh8, Sh4, Sh2, Sh1, ShL, ShR, ShB, ShOut};
    assign flags = {Z, N, C, V};

    alu_ctrl_flags #(.WIDTH(16), .FLAG_RST(4'b0101)) dut (
        .Clock(Clock), .Reset(Reset), .OpValid(OpValid), .OpReady(OpReady),
        .Opcode(Opcode), .ShAmt(ShAmt),
        .SUB(SUB), .ZeroA(ZeroA), .CIn(CIn), .FAOut(FAOut),
        .AND(AND), .OR(OR), .XOR(XOR), .NOT(NOT), .NAND(NAND), .NOR(NOR),
        .Sh8(Sh8), .Sh4(Sh4), .Sh2(Sh2), .Sh1(Sh1),
        .ShL(ShL), .ShR(ShR), .ShB(ShB), .ShOut(ShOut),
        .A_MSB(A_MSB), .B_MSB(B_MSB), .Sum_MSB(Sum_MSB), .COut_MSB(COut_MSB),
        .Out_MSB(Out_MSB), .ResultZero(ResultZero),
        .ExecStrobe(ExecStrobe), .WrEn(WrEn), .FlagsValid(FlagsValid),
        .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 Clock = ~Clock;

    function automatic logic [17:0] bitv(input int i);
        return 18'(1) << i;
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_slice(input logic a, input logic b, input logic s,
                             input logic co, input logic om, input logic rz);
        A_MSB = a; B_MSB = b; Sum_MSB = s; COut_MSB = co; Out_MSB = om; ResultZero = rz;
    endtask

    // Issue one op from IDLE and capture what the DUT shows in EXEC and in CAP.
    task automatic run_op(input logic [3:0] op, input logic [3:0] sh,
                          output logic [17:0] x_ctrl, output logic [2:0] x_strb,
                          output logic [3:0] x_flags, output logic x_fv,
                          output logic [17:0] x_ctrl_cap);
        OpValid = 1'b1; Opcode = op; ShAmt = sh;
        step();
        OpValid = 1'b0;
        x_ctrl = ctrl;
        x_strb = {ExecStrobe, WrEn, OpReady};
        step();
        x_flags = flags;
        x_fv = FlagsValid;
        x_ctrl_cap = ctrl;
        step();
    endtask

    task automatic test_reset();
        Reset = 1'b1; OpValid = 1'b1; Opcode = 4'h0; ShAmt = 4'h0;
        set_slice(0, 0, 0, 0, 0, 0);
        step();
        step();
        if (OpReady !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", OpReady); end
        checks++;
        if (ctrl !== 18'd0) begin failures++; $display("FAIL rst_ctrl: got %b want 0", ctrl); end
        checks++;
        if (flags !== 4'b0101) begin failures++; $display("FAIL rst_flags: got %b want 0101", flags); end
        checks++;
        if ({ExecStrobe, WrEn, FlagsValid} !== 3'b000) begin
            failures++; $display("FAIL rst_strobes: got %b want 000", {ExecStrobe, WrEn, FlagsValid});
        end
        checks++;
        Reset = 1'b0; OpValid = 1'b0;
        step();
        if (ExecStrobe !== 1'b0) begin failures++; $display("FAIL rst_held_valid: got %b want 0", ExecStrobe); end
        checks++;
    endtask

    task automatic test_cmp_nop();
        logic [17:0] xc, xcc; logic [2:0] xs; logic [3:0] xf; logic xv;
        set_slice(0, 0, 0, 1, 0, 1);
        run_op(4'hE, 4'h0, xc, xs, xf, xv, xcc);
        if (xc !== (bitv(C_SUB) | bitv(C_CIN) | bitv(C_FA))) begin
            failures++; $display("FAIL cmp_ctrl: got %b", xc);
        end
        checks++;
        if (xs !== 3'b100) begin failures++; $display("FAIL cmp_strobe_wren_ready: got %b want 100", xs); end
        checks++;
        if (xf !== 4'b1010 || xv !== 1'b1) begin
            failures++; $display("FAIL cmp_flags: got %b fv=%b want 1010 fv=1", xf, xv);
        end
        checks++;
        set_slice(1, 0, 1, 0, 1, 0);
        run_op(4'hF, 4'h0, xc, xs, xf, xv, xcc);
        if (xc !== 18'd0 || xs !== 3'b100) begin
            failures++; $display("FAIL nop_exec: ctrl=%b strb=%b want 0 and 100", xc, xs);
        end
        checks++;
        if (xf !== 4'b1010 || xv !== 1'b1) begin
            failures++; $display("FAIL nop_flags: got %b fv=%b want 1010 fv=1", xf, xv);
        end
        checks++;
        if (FlagsValid !== 1'b0) begin failures++; $display("FAIL nop_fv_pulse: got %b want 0", FlagsValid); end
        checks++;
    endtask

    task automatic test_add();
        logic [17:0] xc, xcc; logic [2:0] xs; logic [3:0] xf; logic xv;
        set_slice(0, 0, 1, 0, 0, 0);
        run_op(4'h0, 4'h0, xc, xs, xf, xv, xcc);
        if (xc !== bitv(C_FA)) begin failures++; $display("FAIL add_ctrl: got %b want %b", xc, bitv(C_FA)); end
        checks++;
        if (xs !== 3'b110) begin failures++; $display("FAIL add_strobe_wren_ready: got %b want 110", xs); end
        checks++;
        if (xf !== 4'b0101 || xv !== 1'b1) begin
            failures++; $display("FAIL add_flags: got %b fv=%b want 0101 fv=1", xf, xv);
        end
        checks++;
        if (xcc !== 18'd0) begin failures++; $display("FAIL add_cap_ctrl: got %b want 0", xcc); end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] rdy;
        set_slice(0, 1, 1, 1, 0, 0);
        OpValid = 1'b1; Opcode = 4'h2; ShAmt = 4'h0;
        rdy[3] = OpReady;
        step();
        rdy[2] = OpReady;
        if (ctrl !== (bitv(C_SUB) | bitv(C_CIN) | bitv(C_FA))) begin
            failures++; $display("FAIL b2b_sub_ctrl: got %b", ctrl);
        end
        checks++;
        Opcode = 4'h3;
        step();
        rdy[1] = OpReady;
        if (flags !== 4'b0111 || FlagsValid !== 1'b1) begin
            failures++; $display("FAIL b2b_sub_flags: got %b fv=%b want 0111 fv=1", flags, FlagsValid);
        end
        checks++;
        set_slice(1, 1, 0, 1, 0, 1);
        step();
        rdy[0] = OpReady;
        OpValid = 1'b0;
        if (ctrl !== (bitv(C_SUB) | bitv(C_CIN) | bitv(C_FA)) || ExecStrobe !== 1'b1) begin
            failures++; $display("FAIL b2b_sbc_cin: got %b strobe=%b", ctrl, ExecStrobe);
        end
        checks++;
        if (rdy !== 4'b1010) begin failures++; $display("FAIL b2b_ready_pattern: got %b want 1010", rdy); end
        checks++;
        step();
        if (flags !== 4'b1010 || FlagsValid !== 1'b1) begin
            failures++; $display("FAIL b2b_sbc_flags: got %b fv=%b want 1010 fv=1", flags, FlagsValid);
        end
        checks++;
        step();
        if (OpReady !== 1'b1 || ExecStrobe !== 1'b0) begin
            failures++; $display("FAIL b2b_idle: ready=%b strobe=%b want 1 0", OpReady, ExecStrobe);
        end
        checks++;
    endtask

    task automatic test_shift();
        logic [17:0] xc, xcc; logic [2:0] xs; logic [3:0] xf; logic xv;
        set_slice(1, 0, 0, 0, 1, 0);
        run_op(4'hC, 4'b1010, xc, xs, xf, xv, xcc);
        if (xc !== (bitv(C_SH8) | bitv(C_SH2) | bitv(C_SHR) | bitv(C_SHOUT))) begin
            failures++; $display("FAIL lsr_ctrl: got %b", xc);
        end
        checks++;
        if (xf !== 4'b0110) begin failures++; $display("FAIL lsr_flags: got %b want 0110", xf); end
        checks++;
        set_slice(1, 0, 0, 0, 0, 1);
        run_op(4'hD, 4'b0101, xc, xs, xf, xv, xcc);
        if (xc !== (bitv(C_SH4) | bitv(C_SH1) | bitv(C_SHL) | bitv(C_SHB) | bitv(C_SHOUT))) begin
            failures++; $display("FAIL lslb_ctrl: got %b", xc);
        end
        checks++;
        if (xf !== 4'b1010) begin failures++; $display("FAIL lslb_flags: got %b want 1010", xf); end
        checks++;
        run_op(4'hB, 4'b0000, xc, xs, xf, xv, xcc);
        if (xc !== (bitv(C_SHL) | bitv(C_SHOUT))) begin
            failures++; $display("FAIL lsl_zero_amt_ctrl: got %b", xc);
        end
        checks++;
    endtask

    task automatic test_logic();
        logic [17:0] xc, xcc; logic [2:0] xs; logic [3:0] xf; logic xv;
        int sel [6] = '{C_AND, C_OR, C_XOR, C_NOT, C_NAND, C_NOR};
        for (int i = 0; i < 6; i++) begin
            set_slice(1, 0, 0, 0, i[0], i[1]);
            run_op(4'(5 + i), 4'hF, xc, xs, xf, xv, xcc);
            if (xc !== bitv(sel[i])) begin
                failures++; $display("FAIL logic_ctrl op=%0d: got %b want %b", 5 + i, xc, bitv(sel[i]));
            end
            checks++;
            if (xf !== {i[1], i[0], 1'b1, 1'b0}) begin
                failures++; $display("FAIL logic_flags op=%0d: got %b want %b", 5 + i, xf, {i[1], i[0], 1'b1, 1'b0});
            end
            checks++;
        end
    endtask

    task automatic test_arith();
        logic [17:0] xc, xcc; logic [2:0] xs; logic [3:0] xf; logic xv;
        set_slice(1, 1, 1, 0, 0, 0);
        run_op(4'h4, 4'h0, xc, xs, xf, xv, xcc);
        if (xc !== (bitv(C_SUB) | bitv(C_ZA) | bitv(C_CIN) | bitv(C_FA))) begin
            failures++; $display("FAIL neg_ctrl: got %b", xc);
        end
        checks++;
        if (xf !== 4'b0101) begin failures++; $display("FAIL neg_flags: got %b want 0101", xf); end
        checks++;
        set_slice(1, 1, 0, 1, 0, 1);
        run_op(4'h1, 4'h0, xc, xs, xf, xv, xcc);
        if (xc !== bitv(C_FA)) begin failures++; $display("FAIL adc_c0_ctrl: got %b", xc); end
        checks++;
        if (xf !== 4'b1011) begin failures++; $display("FAIL adc_flags: got %b want 1011", xf); end
        checks++;
        set_slice(0, 1, 0, 0, 0, 0);
        run_op(4'h3, 4'h0, xc, xs, xf, xv, xcc);
        if (xc !== (bitv(C_SUB) | bitv(C_CIN) | bitv(C_FA))) begin
            failures++; $display("FAIL sbc_c1_ctrl: got %b", xc);
        end
        checks++;
        if (xf !== 4'b0000) begin failures++; $display("FAIL sbc_flags: got %b want 0000", xf); end
        checks++;
    endtask

    task automatic test_reset_mid_op();
        set_slice(0, 0, 1, 1, 0, 1);
        OpValid = 1'b1; Opcode = 4'h0;
        step();
        OpValid = 1'b0;
        if (ExecStrobe !== 1'b1) begin failures++; $display("FAIL midrst_exec: got %b want 1", ExecStrobe); end
        checks++;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        if (OpReady !== 1'b1 || ctrl !== 18'd0) begin
            failures++; $display("FAIL midrst_idle: ready=%b ctrl=%b want 1 0", OpReady, ctrl);
        end
        checks++;
        if (flags !== 4'b0101 || FlagsValid !== 1'b0) begin
            failures++; $display("FAIL midrst_flags: got %b fv=%b want 0101 fv=0", flags, FlagsValid);
        end
        checks++;
        step();
        if (flags !== 4'b0101 || FlagsValid !== 1'b0 || ExecStrobe !== 1'b0) begin
            failures++; $display("FAIL midrst_after: flags=%b fv=%b strobe=%b", flags, FlagsValid, ExecStrobe);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_cmp_nop();
        test_add();
        test_back_to_back();
        test_shift();
        test_logic();
        test_arith();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
